// File: rtl/pulse_event_counter_if.sv
// Control and status bundle for the multi-channel qualified pulse counter.
// slave is the counter side; master is the controlling side.
interface pulse_event_counter_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic                clr;
    logic                arm;
    logic [CH-1:0]       ch_en;
    logic [CH-1:0]       sense_in;
    logic                armed;
    logic [CH*CNT_W-1:0] count;
    logic [CH-1:0]       evt;
    logic [CH-1:0]       ovf;

    modport master (
        output clr, arm, ch_en, sense_in,
        input  armed, count, evt, ovf
    );

    modport slave (
        input  clr, arm, ch_en, sense_in,
        output armed, count, evt, ovf
    );
endinterface

// File: rtl/pulse_event_counter.sv
// Per-channel synchronised pulse-width qualifier feeding saturating/wrapping event counters.
// Latency: count/evt update on the 3rd clk edge after sense_in is first sampled low; no backpressure.
module pulse_event_counter #(
    parameter int CH      = 4,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 31,
    parameter int MIN_LEN = 1500000,
    parameter int MAX_LEN = 0,
    parameter int SAT     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    pulse_event_counter_if.slave   bus
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } st_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CH-1:0]    r_s0, r_s1, r_s2;
    logic [CH-1:0]    w_rise, w_act;
    logic             r_armed;

    st_t              r_state   [CH];
    st_t              w_state_nxt [CH];
    logic [LEN_W-1:0] r_len     [CH];
    logic [LEN_W-1:0] w_len_nxt [CH];
    logic [CH-1:0]    r_qual, w_qual_nxt;

    logic [CNT_W-1:0] r_count [CH];
    logic [CH-1:0]    r_evt, r_ovf;

    // Length is widened so the window compare is exact for any LEN_W vs MIN_LEN/MAX_LEN.
    function automatic logic f_qualifies(input logic [LEN_W-1:0] len);
        logic [63:0] w_l;
        w_l = 64'(len);
        return (w_l >= 64'(MIN_LEN)) && ((MAX_LEN == 0) || (w_l <= 64'(MAX_LEN)));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s0 <= bus.sense_in;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    assign w_rise = r_s1 & ~r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (bus.arm) begin
            r_armed <= 1'b1;
        end
    end

    assign w_act = {CH{r_armed}} & bus.ch_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_len[i]   <= '0;
            end
            r_qual <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_len[i]   <= w_len_nxt[i];
            end
            r_qual <= w_qual_nxt;
        end
    end

    // Abort on loss of act takes priority over the fall evaluation.
    always_comb begin
        w_qual_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_len_nxt[i]   = r_len[i];
            if (bus.clr) begin
                w_state_nxt[i] = ST_IDLE;
                w_len_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_rise[i] && w_act[i]) begin
                            w_state_nxt[i] = ST_MEASURE;
                            w_len_nxt[i]   = LEN_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (!w_act[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                            w_len_nxt[i]   = '0;
                        end else if (r_s1[i]) begin
                            if (r_len[i] != LEN_MAX) begin
                                w_len_nxt[i] = r_len[i] + LEN_W'(1);
                            end
                        end else begin
                            w_state_nxt[i] = ST_IDLE;
                            w_qual_nxt[i]  = f_qualifies(r_len[i]);
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_count[i] <= '0;
            end
            r_evt <= '0;
            r_ovf <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < CH; i++) begin
                r_count[i] <= '0;
            end
            r_evt <= '0;
            r_ovf <= '0;
        end else begin
            r_evt <= r_qual;
            for (int i = 0; i < CH; i++) begin
                if (r_qual[i]) begin
                    if (r_count[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                        if (SAT == 0) begin
                            r_count[i] <= '0;
                        end
                    end else begin
                        r_count[i] <= r_count[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_count_out
        assign bus.count[g*CNT_W +: CNT_W] = r_count[g];
    end

    assign bus.armed = r_armed;
    assign bus.evt   = r_evt;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_pulse_event_counter.sv
// Directed bench: three counter instances (window, unlimited window, wrap mode) share one stimulus.
module tb_pulse_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       arm;
    logic [1:0] ch_en;
    logic [1:0] sense;

    int errors = 0;
    int checks = 0;
    int evt0_a = 0;
    int evt1_a = 0;
    int evt1_c = 0;

    always #5 clk = ~clk;

    pulse_event_counter_if #(.CH(2), .CNT_W(4)) ifa ();
    pulse_event_counter_if #(.CH(2), .CNT_W(4)) ifb ();
    pulse_event_counter_if #(.CH(2), .CNT_W(4)) ifc ();

    assign ifa.clr = clr;  assign ifa.arm = arm;  assign ifa.ch_en = ch_en;  assign ifa.sense_in = sense;
    assign ifb.clr = clr;  assign ifb.arm = arm;  assign ifb.ch_en = ch_en;  assign ifb.sense_in = sense;
    assign ifc.clr = clr;  assign ifc.arm = arm;  assign ifc.ch_en = ch_en;  assign ifc.sense_in = sense;

    pulse_event_counter #(.CH(2), .CNT_W(4), .LEN_W(8), .MIN_LEN(5), .MAX_LEN(10), .SAT(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pulse_event_counter #(.CH(2), .CNT_W(4), .LEN_W(8), .MIN_LEN(5), .MAX_LEN(0), .SAT(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    pulse_event_counter #(.CH(2), .CNT_W(4), .LEN_W(8), .MIN_LEN(5), .MAX_LEN(10), .SAT(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    always @(negedge clk) begin
        if (ifa.evt[0]) evt0_a++;
        if (ifa.evt[1]) evt1_a++;
        if (ifc.evt[1]) evt1_c++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m, input int n);
        sense = sense | m;
        tick(n);
        sense = sense & ~m;
    endtask

    task automatic pulse_settle(input logic [1:0] m, input int n);
        pulse(m, n);
        tick(6);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int b0;
        rst = 1'b1; clr = 1'b0; arm = 1'b0; ch_en = 2'b11; sense = 2'b00;
        tick(3);
        checks++; if (ifa.armed !== 1'b0) begin errors++; $display("FAIL reset_armed got %0h exp 0", ifa.armed); end
        checks++; if (ifa.count !== 8'h00) begin errors++; $display("FAIL reset_count got %0h exp 00", ifa.count); end
        checks++; if (ifa.evt !== 2'b00) begin errors++; $display("FAIL reset_evt got %0h exp 0", ifa.evt); end
        checks++; if (ifa.ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got %0h exp 0", ifa.ovf); end
        rst = 1'b0;
        tick(2);
        b0 = evt0_a;
        pulse_settle(2'b01, 20);
        checks++; if (ifa.count !== 8'h00) begin errors++; $display("FAIL unarmed_count got %0h exp 00", ifa.count); end
        checks++; if (evt0_a - b0 !== 0) begin errors++; $display("FAIL unarmed_evt got %0d exp 0", evt0_a - b0); end
        checks++; if (ifa.armed !== 1'b0) begin errors++; $display("FAIL unarmed_armed got %0h exp 0", ifa.armed); end
    endtask

    task automatic test_basic();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        checks++; if (ifa.armed !== 1'b1) begin errors++; $display("FAIL arm_set got %0h exp 1", ifa.armed); end
        pulse(2'b01, 5);
        tick(3);
        checks++; if (ifa.count[3:0] !== 4'd0) begin errors++; $display("FAIL latency_early_count got %0d exp 0", ifa.count[3:0]); end
        checks++; if (ifa.evt !== 2'b00) begin errors++; $display("FAIL latency_early_evt got %0h exp 0", ifa.evt); end
        tick(1);
        checks++; if (ifa.evt !== 2'b01) begin errors++; $display("FAIL len5_evt got %0h exp 1", ifa.evt); end
        checks++; if (ifa.count[3:0] !== 4'd1) begin errors++; $display("FAIL len5_count got %0d exp 1", ifa.count[3:0]); end
        tick(1);
        checks++; if (ifa.evt !== 2'b00) begin errors++; $display("FAIL len5_evt_one_cycle got %0h exp 0", ifa.evt); end
        tick(4);
        pulse_settle(2'b01, 4);
        checks++; if (ifa.count[3:0] !== 4'd1) begin errors++; $display("FAIL len4_reject got %0d exp 1", ifa.count[3:0]); end
    endtask

    task automatic test_window();
        do_clr();
        pulse_settle(2'b01, 10);
        checks++; if (ifa.count[3:0] !== 4'd1) begin errors++; $display("FAIL len10_a got %0d exp 1", ifa.count[3:0]); end
        checks++; if (ifb.count[3:0] !== 4'd1) begin errors++; $display("FAIL len10_b got %0d exp 1", ifb.count[3:0]); end
        pulse_settle(2'b01, 11);
        checks++; if (ifa.count[3:0] !== 4'd1) begin errors++; $display("FAIL len11_a got %0d exp 1", ifa.count[3:0]); end
        checks++; if (ifb.count[3:0] !== 4'd2) begin errors++; $display("FAIL len11_b got %0d exp 2", ifb.count[3:0]); end
        pulse_settle(2'b01, 300);
        checks++; if (ifa.count[3:0] !== 4'd1) begin errors++; $display("FAIL len300_a got %0d exp 1", ifa.count[3:0]); end
        checks++; if (ifb.count[3:0] !== 4'd3) begin errors++; $display("FAIL len300_b got %0d exp 3", ifb.count[3:0]); end
    endtask

    task automatic test_overflow();
        int b1a;
        int b1c;
        do_clr();
        b1a = evt1_a;
        b1c = evt1_c;
        for (int k = 0; k < 15; k++) pulse_settle(2'b10, 6);
        checks++; if (ifa.count[7:4] !== 4'd15) begin errors++; $display("FAIL pre_ovf_count_a got %0d exp 15", ifa.count[7:4]); end
        checks++; if (ifa.ovf !== 2'b00) begin errors++; $display("FAIL pre_ovf_flag_a got %0h exp 0", ifa.ovf); end
        checks++; if (ifc.count[7:4] !== 4'd15) begin errors++; $display("FAIL pre_ovf_count_c got %0d exp 15", ifc.count[7:4]); end
        pulse_settle(2'b10, 6);
        checks++; if (ifa.count[7:4] !== 4'd15) begin errors++; $display("FAIL sat_count got %0d exp 15", ifa.count[7:4]); end
        checks++; if (ifa.ovf !== 2'b10) begin errors++; $display("FAIL sat_ovf got %0h exp 2", ifa.ovf); end
        checks++; if (evt1_a - b1a !== 16) begin errors++; $display("FAIL sat_evt_pulses got %0d exp 16", evt1_a - b1a); end
        checks++; if (ifa.count[3:0] !== 4'd0) begin errors++; $display("FAIL sat_ch0_idle got %0d exp 0", ifa.count[3:0]); end
        checks++; if (ifc.count[7:4] !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", ifc.count[7:4]); end
        checks++; if (ifc.ovf !== 2'b10) begin errors++; $display("FAIL wrap_ovf got %0h exp 2", ifc.ovf); end
        checks++; if (evt1_c - b1c !== 16) begin errors++; $display("FAIL wrap_evt_pulses got %0d exp 16", evt1_c - b1c); end
        tick(3);
        checks++; if (ifa.ovf !== 2'b10) begin errors++; $display("FAIL ovf_sticky got %0h exp 2", ifa.ovf); end
    endtask

    task automatic test_abort_clear();
        int b0;
        int b1;
        do_clr();
        checks++; if (ifa.ovf !== 2'b00) begin errors++; $display("FAIL clr_ovf got %0h exp 0", ifa.ovf); end
        b1 = evt1_a;
        sense = sense | 2'b10;
        tick(4);
        ch_en = 2'b01;
        tick(4);
        sense = sense & ~2'b10;
        tick(6);
        ch_en = 2'b11;
        tick(2);
        checks++; if (ifa.count[7:4] !== 4'd0) begin errors++; $display("FAIL abort_count got %0d exp 0", ifa.count[7:4]); end
        checks++; if (evt1_a - b1 !== 0) begin errors++; $display("FAIL abort_evt got %0d exp 0", evt1_a - b1); end
        for (int k = 0; k < 3; k++) pulse_settle(2'b01, 6);
        checks++; if (ifa.count[3:0] !== 4'd3) begin errors++; $display("FAIL three_pulses got %0d exp 3", ifa.count[3:0]); end
        b0 = evt0_a;
        sense = sense | 2'b01;
        tick(4);
        do_clr();
        checks++; if (ifa.count[3:0] !== 4'd0) begin errors++; $display("FAIL midclr_count got %0d exp 0", ifa.count[3:0]); end
        checks++; if (ifa.armed !== 1'b1) begin errors++; $display("FAIL midclr_armed got %0h exp 1", ifa.armed); end
        tick(4);
        sense = sense & ~2'b01;
        tick(6);
        checks++; if (evt0_a - b0 !== 0) begin errors++; $display("FAIL midclr_evt got %0d exp 0", evt0_a - b0); end
        checks++; if (ifa.count[3:0] !== 4'd0) begin errors++; $display("FAIL midclr_after_fall got %0d exp 0", ifa.count[3:0]); end
        pulse_settle(2'b01, 6);
        checks++; if (ifa.count[3:0] !== 4'd1) begin errors++; $display("FAIL post_clr_pulse got %0d exp 1", ifa.count[3:0]); end
    endtask

    task automatic test_back_to_back();
        int b0;
        int b1;
        do_clr();
        pulse(2'b11, 7);
        tick(3);
        checks++; if (ifa.evt !== 2'b00) begin errors++; $display("FAIL dual_early_evt got %0h exp 0", ifa.evt); end
        tick(1);
        checks++; if (ifa.evt !== 2'b11) begin errors++; $display("FAIL dual_evt got %0h exp 3", ifa.evt); end
        checks++; if (ifa.count !== 8'h11) begin errors++; $display("FAIL dual_count got %0h exp 11", ifa.count); end
        tick(5);
        b0 = evt0_a;
        b1 = evt1_a;
        pulse(2'b11, 7);
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        checks++; if (ifa.evt !== 2'b00) begin errors++; $display("FAIL clr_eval_evt got %0h exp 0", ifa.evt); end
        checks++; if (ifa.count !== 8'h00) begin errors++; $display("FAIL clr_eval_count got %0h exp 00", ifa.count); end
        tick(4);
        checks++; if ((evt0_a - b0) + (evt1_a - b1) !== 0) begin errors++; $display("FAIL clr_eval_pulses got %0d exp 0", (evt0_a - b0) + (evt1_a - b1)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_overflow();
        test_abort_clear();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_event_counter.md
Name: pulse_event_counter

Overview:
Multi-channel qualified pulse counter for the LED display sensor path. Each channel synchronizes an asynchronous sensor level and measures how long each high pulse lasts. It counts only pulses whose length falls inside a programmable window. It generalises the single-channel obstacle counter with channel count, width and window parameters, plus saturate/wrap mode, per-channel enable, overflow flags and event strobes.

Parameters:
CH, 4, number of independent sensor channels (>=1)
CNT_W, 8, width of each event counter
LEN_W, 31, width of each pulse-length counter
MIN_LEN, 1500000, minimum qualifying high length in clk cycles (>=1)
MAX_LEN, 0, maximum qualifying high length in cycles; 0 = no upper limit
SAT, 1, 1 = counter saturates at all-ones; 0 = counter wraps to 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear of counts, flags and measurements
arm  in  1  one-cycle or level request; sets the armed state
ch_en  in  CH  per-channel enable, synchronous
sense_in  in  CH  asynchronous sensor levels, one bit per channel
armed  out  1  armed state
count  out  CH*CNT_W  event counts; channel i occupies bits [i*CNT_W +: CNT_W]
evt  out  CH  one-cycle strobe per qualified event
ovf  out  CH  sticky overflow flag per channel

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. On reset, armed, count, evt and ovf are 0, sync flops are 0, length counters are 0 and all FSMs are IDLE.
- Synchronizer, per channel:
  - s0 <= sense_in, s1 <= s0, s2 <= s1.
  - rise = s1 & ~s2; fall = ~s1 & s2.
  - clr does not affect the sync chain.
- Armed:
  - armed <= 1 on any cycle with arm = 1.
  - Only rst returns armed to 0; clr does not affect it.
- Per-channel FSM, with act = armed & ch_en[i]:
  - IDLE: on rise & act -> MEASURE, len <= 1. A rise while act = 0 is ignored; the channel waits for the next rise.
  - MEASURE, s1 = 1: len <= len + 1, saturating at 2^LEN_W - 1.
  - MEASURE, fall: evaluate, then -> IDLE. Qualified = (len >= MIN_LEN) && (MAX_LEN == 0 || len <= MAX_LEN), using the saturated len.
  - MEASURE, act = 0 at any cycle: abort -> IDLE, no event, len <= 0.
- Pulse length: len equals the number of cycles s1 was high. A synchronous N-cycle high pulse on sense_in gives len = N.
- Qualified event:
  - Registered on the clock edge following the fall cycle: evt[i] = 1 for exactly one cycle and the count updates on the same edge.
  - Latency: count changes on the 3rd rising edge after the edge that first samples sense_in low.
- Count update on a qualified event:
  - count < max: count + 1.
  - count == 2^CNT_W - 1 with SAT = 1: hold at max, ovf[i] <= 1.
  - count == 2^CNT_W - 1 with SAT = 0: wrap to 0, ovf[i] <= 1.
  - evt pulses in both cases.
- ovf is sticky; only clr or rst clears it.
- clr, highest synchronous priority:
  - count, ovf, evt and len are cleared and all FSMs go to IDLE.
  - A pulse in progress is discarded; its later fall yields no event.
  - clr and arm in the same cycle: clears take effect and armed = 1.
  - clr in the same cycle as a qualifying fall: clr wins, count = 0, evt = 0.
- Channels are fully independent. Simultaneous events on several channels each update their own count in the same cycle.
- Reset asserted mid-pulse: immediate return to reset values. After release, the channel needs a fresh rise, and arm must be re-asserted.

Test Plan:
Use CH=2, CNT_W=4, LEN_W=8, MIN_LEN=5, MAX_LEN=10, SAT=1 unless noted.
1. Reset, arm never asserted, 20-cycle pulse on ch0 -> count = 0, evt never 1, armed = 0.
2. Arm, ch_en=2'b11:
   - 5-cycle pulse on ch0 -> evt[0] for one cycle, count0 = 1 on the 3rd edge after sense_in low.
   - Then a 4-cycle pulse -> count0 stays 1.
3. Window edges: 10-cycle pulse -> counted (count0 = 1); 11-cycle pulse -> rejected (count0 stays 1). Rerun with MAX_LEN=0: a 300-cycle pulse saturates len at 255 and is counted.
4. Overflow: 16 qualifying pulses on ch1 with SAT=1 -> count1 = 15, ovf[1] = 1, evt pulsed 16 times. With SAT=0 -> count1 = 0, ovf[1] = 1.
5. Abort and clear:
   - ch_en[1] dropped mid-pulse -> no event.
   - clr mid-pulse on ch0 with count0 = 3 -> count0 = 0 and that pulse's fall gives no evt.
   - The next 6-cycle pulse -> count0 = 1.
6. Simultaneous 7-cycle pulses on ch0 and ch1 -> evt = 2'b11 in the same cycle, both counts +1. Clr asserted coincident with the fall-evaluation edge -> counts 0, evt = 0.
